systolic_host_if: RTL

Parametrised byte-wide host interface for an N×N systolic matrix-multiply core, generalising the fixed 4×4 parallel wrapper. It holds operand matrices A and B in byte-addressable storage, sequences a run through an explicit IDLE/RUN/DONE state machine, and snapshots the core's results on completion. A run-cycle watchdog, a sticky error flag, registered read data and a write lock during a run are added. It sits between the chip's parallel pin interface and the systolic core.

---
 rtl/systolic_host_if.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/systolic_host_if.sv
// systolic_host_if: byte-wide host port for an NxN systolic matrix-multiply core.
// Holds operands A/B and result snapshot R, sequences IDLE/RUN/DONE runs with a
// watchdog, a sticky error flag and a registered one-cycle read path.
module systolic_host_if #(
    parameter int unsigned N       = 4,
    parameter int unsigned A_W     = 16,
    parameter int unsigned B_W     = 8,
    parameter int unsigned R_W     = 32,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    addr,
    input  logic                 wr_en,
    input  logic [7:0]           wr_data,
    input  logic                 rd_en,
    output logic [7:0]           rd_data,
    output logic                 rd_valid,
    input  logic                 start,
    output logic                 ready,
    output logic                 done,
    output logic                 err,
    output logic                 core_start,
    output logic [N*N*A_W-1:0]   core_a,
    output logic [N*N*B_W-1:0]   core_b,
    input  logic [N*N*R_W-1:0]   core_result,
    input  logic                 core_done
);

    localparam int unsigned AB        = A_W / 8;
    localparam int unsigned BB        = B_W / 8;
    localparam int unsigned RB        = R_W / 8;
    localparam int unsigned A_BYTES   = N * N * AB;
    localparam int unsigned B_BYTES   = N * N * BB;
    localparam int unsigned R_BYTES   = N * N * RB;
    localparam int unsigned B_BASE    = A_BYTES;
    localparam int unsigned R_BASE    = B_BASE + B_BYTES;
    localparam int unsigned R_END     = R_BASE + R_BYTES;
    localparam int unsigned CTRL_ADDR = (32'd1 << ADDR_W) - 32'd2;
    localparam int unsigned STAT_ADDR = (32'd1 << ADDR_W) - 32'd1;
    localparam int unsigned CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [N*N*A_W-1:0] a_q, a_d;
    logic [N*N*B_W-1:0] b_q, b_d;
    logic [N*N*R_W-1:0] r_q, r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               timeout_q, timeout_d;
    logic               core_start_q, core_start_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;

    // Address decode. Operand/result storage is kept as flat little-endian byte
    // vectors, so a region byte offset maps directly onto bit offset*8.
    logic [31:0] addr_u;
    logic [31:0] a_off, b_off, r_off;
    logic        in_a, in_b, in_r, is_ctrl, is_stat;

    assign addr_u  = 32'(addr);
    assign a_off   = addr_u;
    assign b_off   = addr_u - B_BASE;
    assign r_off   = addr_u - R_BASE;
    assign in_a    = (addr_u < A_BYTES);
    assign in_b    = (addr_u >= B_BASE) && (addr_u < R_BASE);
    assign in_r    = (addr_u >= R_BASE) && (addr_u < R_END);
    assign is_ctrl = (addr_u == CTRL_ADDR);
    assign is_stat = (addr_u == STAT_ADDR);

    // Control strobes and run events.
    logic ctrl_wr, start_req, clr_done, clr_err;
    logic run, opnd_wr, capture, timeout_hit, launch, err_event;
    logic busy;
    logic [7:0] status;

    assign ctrl_wr     = wr_en & is_ctrl;
    assign start_req   = start | (ctrl_wr & wr_data[0]);
    assign clr_done    = ctrl_wr & wr_data[1];
    assign clr_err     = ctrl_wr & wr_data[2];
    assign run         = (state_q == StRun);
    assign opnd_wr     = wr_en & (in_a | in_b);
    assign capture     = run & core_done;
    // core_done has priority over a coinciding watchdog expiry.
    assign timeout_hit = run & ~core_done & (cnt_q == CNT_W'(TIMEOUT));
    assign launch      = start_req & ~run;
    assign err_event   = (run & (opnd_wr | start_req)) | timeout_hit;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; in DONE a start request beats clear_done.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_req) state_d = StRun;
            end
            StRun: begin
                if (core_done || timeout_hit) state_d = StDone;
            end
            StDone: begin
                if (start_req) begin
                    state_d = StRun;
                end else if (clr_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: handshake levels and the core start pulse request.
    always_comb begin
        ready        = 1'b0;
        done         = 1'b0;
        busy         = 1'b0;
        core_start_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready        = 1'b1;
                core_start_d = start_req;
            end
            StRun: begin
                busy = 1'b1;
            end
            StDone: begin
                ready        = 1'b1;
                done         = 1'b1;
                core_start_d = start_req;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    assign status = {4'b0000, timeout_q, err_q, done, busy};

    // Operand writes are locked out while a run is in progress.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (wr_en && !run) begin
            if (in_a) begin
                a_d[a_off*8 +: 8] = wr_data;
            end else if (in_b) begin
                b_d[b_off*8 +: 8] = wr_data;
            end
        end
    end

    // Result snapshot is taken only on core_done inside a run.
    always_comb begin
        r_d = r_q;
        if (capture) begin
            r_d = core_result;
        end
    end

    // Watchdog counter: zero at run entry, counts every run cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (launch) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Sticky flags; a same-cycle error event overrides clear_err.
    always_comb begin
        err_d     = err_q;
        timeout_d = timeout_q;
        if (err_event) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end
        if (timeout_hit) begin
            timeout_d = 1'b1;
        end else if (clr_err || (launch && state_q == StDone)) begin
            timeout_d = 1'b0;
        end
    end

    // Read mux samples pre-write state; rd_data holds between reads.
    always_comb begin
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            rd_data_d = 8'h00;
            if (in_a) begin
                rd_data_d = a_q[a_off*8 +: 8];
            end else if (in_b) begin
                rd_data_d = b_q[b_off*8 +: 8];
            end else if (in_r) begin
                rd_data_d = r_q[r_off*8 +: 8];
            end else if (is_stat) begin
                rd_data_d = status;
            end
        end
    end

    // Datapath and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            r_q          <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            timeout_q    <= 1'b0;
            core_start_q <= 1'b0;
            rd_data_q    <= 8'h00;
            rd_valid_q   <= 1'b0;
        end else begin
            a_q          <= a_d;
            b_q          <= b_d;
            r_q          <= r_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            timeout_q    <= timeout_d;
            core_start_q <= core_start_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    assign core_a     = a_q;
    assign core_b     = b_q;
    assign core_start = core_start_q;
    assign err        = err_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;

endmodule
